encoder_128b130b: RTL and testbench

Transmit-side 128b/130b block framer for the PHY datapath: accepts 128-bit payload blocks tagged data or control, prepends the 2-bit sync header (01 data, 10 control), and presents 130-bit blocks to the serializer. A one-entry registered output stage decouples upstream and downstream with valid/ready handshakes. Periodic SKP ordered-set block insertion maintains clock compensation at the far-end decoder.

---
 rtl/encoder_128b130b.sv | 110 +++++++++++
 tb/tb_encoder_128b130b.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_128b130b.sv
// encoder_128b130b: 128b/130b transmit framer with a one-entry registered output stage.
// Define ENC130_SKP_INSERT_EN to compile in periodic SKP ordered-set insertion.
module encoder_128b130b #(
  parameter int SKP_INTERVAL = 370
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] data_in,
  input  logic         block_type_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [129:0] encoded_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         skp_inserted
);

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  if (SKP_INTERVAL < 1 || SKP_INTERVAL > 4095) begin : g_bad_interval
    $error("encoder_128b130b: SKP_INTERVAL must be within 1..4095");
  end

  logic [129:0] enc_q, enc_d;
  logic         valid_q, valid_d;
  logic         slot_free;
  logic         accept;
  logic [129:0] new_block;

  // The output register may be refilled whenever it is empty or being drained this cycle.
  assign slot_free   = !valid_q || ready_in;
  assign accept      = valid_in && ready_out;
  assign new_block   = {block_type_in ? HDR_CTRL : HDR_DATA, data_in};
  assign encoded_out = enc_q;
  assign valid_out   = valid_q;

`ifdef ENC130_SKP_INSERT_EN
  typedef enum logic {NORMAL, SKP_PEND} state_e;

  localparam int               CNT_W     = $clog2(SKP_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SKP_INTERVAL);
  localparam logic [129:0]     SKP_BLOCK = {HDR_CTRL, 24'h00_0000, 8'hE1, {12{8'hAA}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             skp_q, skp_d;
  logic             skp_load;

  assign ready_out    = rst_n && (state_q == NORMAL) && slot_free;
  assign skp_load     = (state_q == SKP_PEND) && slot_free;
  assign skp_inserted = skp_q;

  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    skp_d     = 1'b0;
    if (accept) begin
      blk_cnt_d = blk_cnt_q + 1'b1;
      if (blk_cnt_d == CNT_LAST) state_d = SKP_PEND;
    end else if (skp_load) begin
      blk_cnt_d = '0;
      skp_d     = 1'b1;
      state_d   = NORMAL;
    end
  end
`else
  assign ready_out    = rst_n && slot_free;
  assign skp_inserted = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    enc_d   = enc_q;
    valid_d = valid_q;
    if (slot_free) valid_d = 1'b0;
    if (accept) begin
      enc_d   = new_block;
      valid_d = 1'b1;
    end
`ifdef ENC130_SKP_INSERT_EN
    else if (skp_load) begin
      enc_d   = SKP_BLOCK;
      valid_d = 1'b1;
    end
`endif
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_q   <= '0;
      valid_q <= 1'b0;
`ifdef ENC130_SKP_INSERT_EN
      state_q   <= NORMAL;
      blk_cnt_q <= '0;
      skp_q     <= 1'b0;
`endif
    end else begin
      enc_q   <= enc_d;
      valid_q <= valid_d;
`ifdef ENC130_SKP_INSERT_EN
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
      skp_q     <= skp_d;
`endif
    end
  end

endmodule

// File: tb/tb_encoder_128b130b.sv
// Self-checking bench for encoder_128b130b: directed table, hand-written corner sequences,
// and randomized traffic scored against a stream-order reference model.
module tb_encoder_128b130b;

  localparam int TB_INTERVAL = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] data_in;
  logic         block_type_in;
  logic         valid_in;
  logic         ready_out;
  logic [129:0] encoded_out;
  logic         valid_out;
  logic         ready_in;
  logic         skp_inserted;

  int n_cmp  = 0;
  int n_fail = 0;

  encoder_128b130b #(.SKP_INTERVAL(TB_INTERVAL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .block_type_in (block_type_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .encoded_out   (encoded_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .skp_inserted  (skp_inserted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic         t;
    logic         exp_rdy;
    logic         exp_v;
    logic [129:0] exp_enc;
  } vec_t;

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [129:0] frame(input logic [127:0] d, input logic t);
    return {(t ? 2'b10 : 2'b01), d};
  endfunction

  function automatic logic [129:0] skp_block();
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 12; i++) p[i*8 +: 8] = 8'hAA;
    p[12*8 +: 8] = 8'hE1;
    return {2'b10, p};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the expected order of blocks leaving the encoder.
  logic [129:0] exp_q[$];
  int model_cnt   = 0;
  int skp_pulses  = 0;
  int skp_popped  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt  = 0;
      skp_pulses = 0;
      skp_popped = 0;
      check("ready_out_in_reset", 130'(ready_out), 130'd0);
    end else begin
      if (skp_inserted) begin
        skp_pulses++;
        check("skp_pulse_block", encoded_out, skp_block());
        check("skp_pulse_valid", 130'(valid_out), 130'd1);
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("transfer_unexpected", encoded_out, 130'bx);
        end else begin
          logic [129:0] e;
          e = exp_q.pop_front();
          if (e == skp_block()) skp_popped++;
          check("stream_order", encoded_out, e);
        end
      end
      if (valid_in && ready_out) begin
        exp_q.push_back(frame(data_in, block_type_in));
`ifdef ENC130_SKP_INSERT_EN
        model_cnt++;
        if (model_cnt == TB_INTERVAL) begin
          exp_q.push_back(skp_block());
          model_cnt = 0;
        end
`endif
      end
    end
  end

  localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D2 = 128'hA5A5_5A5A_F0F0_0F0F_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  vec_t tbl[7];
  logic [127:0] da, db, dc, dd;
  logic skp_en;

  initial begin
`ifdef ENC130_SKP_INSERT_EN
    skp_en = 1'b1;
`else
    skp_en = 1'b0;
`endif
    tbl[0] = '{1'b1, D0, 1'b0, 1'b1, 1'b1, frame(D0, 1'b0)};
    tbl[1] = '{1'b1, D0, 1'b1, 1'b1, 1'b1, frame(D0, 1'b1)};
    tbl[2] = '{1'b0, D1, 1'b0, 1'b1, 1'b0, frame(D0, 1'b1)};
    tbl[3] = '{1'b1, D1, 1'b0, 1'b1, 1'b1, frame(D1, 1'b0)};
    tbl[4] = '{1'b1, D2, 1'b1, 1'b1, 1'b1, frame(D2, 1'b1)};
    tbl[5] = '{1'b1, D3, 1'b0, !skp_en, 1'b1, skp_en ? skp_block() : frame(D3, 1'b0)};
    tbl[6] = '{1'b1, D3, 1'b0, 1'b1, 1'b1, frame(D3, 1'b0)};

    // Reset held with valid_in high.
    rst_n = 1'b0; valid_in = 1'b1; data_in = D0; block_type_in = 1'b0; ready_in = 1'b1;
    repeat (3) step();
    check("reset_valid_out", 130'(valid_out), 130'd0);
    check("reset_encoded_out", encoded_out, 130'd0);
    check("reset_ready_out", 130'(ready_out), 130'd0);
    check("reset_skp", 130'(skp_inserted), 130'd0);
    rst_n = 1'b1; valid_in = 1'b0;
    step();

    // Framing and first SKP insertion.
    for (int i = 0; i < 7; i++) begin
      valid_in = tbl[i].v; data_in = tbl[i].d; block_type_in = tbl[i].t;
      #1;
      check($sformatf("tbl%0d_ready", i), 130'(ready_out), 130'(tbl[i].exp_rdy));
      step();
      check($sformatf("tbl%0d_valid", i), 130'(valid_out), 130'(tbl[i].exp_v));
      check($sformatf("tbl%0d_enc", i), encoded_out, tbl[i].exp_enc);
    end
    valid_in = 1'b0;
    step();

    // Backpressure: output held for 5 stalled cycles, then drained without loss.
    da = rand128(); db = rand128();
    valid_in = 1'b1; data_in = da; block_type_in = 1'b0; ready_in = 1'b0;
    step();
    data_in = db;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", 130'(ready_out), 130'd0);
      step();
      check("stall_enc", encoded_out, frame(da, 1'b0));
      check("stall_valid", 130'(valid_out), 130'd1);
    end
    ready_in = 1'b1;
    #1;
    check("release_ready", 130'(ready_out), 130'd1);
    step();
    check("release_next", encoded_out, frame(db, 1'b0));
    valid_in = 1'b0;
    step();
    check("release_empty", 130'(valid_out), 130'd0);

    // SKP pending while the last counted block is stalled downstream.
    dc = rand128(); dd = rand128();
    valid_in = 1'b1; data_in = dc; block_type_in = 1'b1; ready_in = 1'b0;
    step();
    data_in = dd; block_type_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("skpstall_ready", 130'(ready_out), 130'd0);
      step();
      check("skpstall_hold", encoded_out, frame(dc, 1'b1));
      check("skpstall_nopulse", 130'(skp_inserted), 130'd0);
    end
    ready_in = 1'b1;
    #1;
    check("skpstall_release_ready", 130'(ready_out), 130'(!skp_en));
    step();
    check("skpstall_load", encoded_out, skp_en ? skp_block() : frame(dd, 1'b0));
    check("skpstall_pulse", 130'(skp_inserted), 130'(skp_en));
    step();
    check("skpstall_after", encoded_out, frame(dd, 1'b0));
    valid_in = 1'b0;
    step();

    // Reset while an SKP is pending discards it and restarts the count.
    for (int i = 0; i < TB_INTERVAL - 1; i++) begin
      valid_in = 1'b1; data_in = rand128(); block_type_in = 1'($urandom);
      step();
    end
    rst_n = 1'b0; valid_in = 1'b0;
    step();
    check("midreset_valid", 130'(valid_out), 130'd0);
    check("midreset_skp", 130'(skp_inserted), 130'd0);
    check("midreset_enc", encoded_out, 130'd0);
    rst_n = 1'b1;
    for (int i = 0; i < TB_INTERVAL; i++) begin
      valid_in = 1'b1; data_in = rand128(); block_type_in = 1'($urandom);
      step();
      check("postreset_noskp", 130'(skp_inserted), 130'd0);
      check("postreset_valid", 130'(valid_out), 130'd1);
    end
    valid_in = 1'b0;
    step();
    check("postreset_skp", 130'(skp_inserted), 130'(skp_en));
    if (skp_en) check("postreset_skp_block", encoded_out, skp_block());

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 399) != 0);
      valid_in      = ($urandom_range(0, 9) < 7);
      ready_in      = ($urandom_range(0, 9) < 6);
      data_in       = rand128();
      block_type_in = 1'($urandom);
      step();
    end

    // Drain: everything the model expects must come out, with matching SKP pulses.
    rst_n = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    repeat (8) step();
    check("drain_empty", 130'(exp_q.size()), 130'd0);
    check("drain_skp_count", 130'(skp_pulses), 130'(skp_popped));
    check("drain_valid", 130'(valid_out), 130'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
